// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage branch resolver for the dual-issue pipe. Each slot's fetch-time
// prediction is compared with the resolved outcome, and registered training and
// redirect pulses are produced for fetch1. Slot 0 is older than slot 1.
//
// The predictor update port is single-ported, so when both slots of a pair are
// branches the second one is parked in a one-entry pending register and emitted
// one cycle later. After any redirect the next SHADOW_CYCLES input pairs are
// wrong-path work and are consumed without producing output.
//
// Parameters
//   SHADOW_CYCLES      wrong-path pairs discarded after a redirect (1..15)
//
// Optional feature
//   BRU_PERF_CNT_EN    when defined, adds saturating perf counters
//                      perf_br_cnt_o (branches resolved) and
//                      perf_mispred_cnt_o (wrong_pred_o pulses).
//
// Ports
//   clock_i, reset_i           clock (posedge) / async active-high reset
//   valid_N_i, is_br_N_i       slot N carries an instruction / a control transfer
//   pc_N_i                     slot N instruction address
//   pred_tk_N_i, pred_tgt_N_i  slot N fetch-time prediction
//   taken_N_i, tgt_N_i         slot N resolved direction / target
//   stall_o                    inputs not consumed this cycle (combinational)
//   update_pc_o, update_tgt_o  PC being trained / BTB target to write
//   last_br_o                  resolved direction for the PHT
//   update_pht_o, update_btb_o PHT train pulse / BTB write pulse
//   wrong_pred_o, fixed_pc_o   mispredict redirect pulse / correct next PC
//   wasnt_branch_o             false BTB hit on a non-branch
//   wasnt_br_pc_o              PC of the false-hit instruction
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int unsigned SHADOW_CYCLES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        valid_0_i,
    input  logic        valid_1_i,
    input  logic        is_br_0_i,
    input  logic        is_br_1_i,
    input  logic [31:0] pc_0_i,
    input  logic [31:0] pc_1_i,
    input  logic        pred_tk_0_i,
    input  logic        pred_tk_1_i,
    input  logic [31:0] pred_tgt_0_i,
    input  logic [31:0] pred_tgt_1_i,
    input  logic        taken_0_i,
    input  logic        taken_1_i,
    input  logic [31:0] tgt_0_i,
    input  logic [31:0] tgt_1_i,
    output logic        stall_o,
    output logic [31:0] update_pc_o,
    output logic [31:0] update_tgt_o,
    output logic        last_br_o,
    output logic        update_pht_o,
    output logic        update_btb_o,
    output logic        wrong_pred_o,
    output logic [31:0] fixed_pc_o,
    output logic        wasnt_branch_o,
    output logic [31:0] wasnt_br_pc_o
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0] perf_br_cnt_o,
    output logic [31:0] perf_mispred_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_PEND,
        ST_SHADOW
    } state_t;

    // Everything one slot would drive onto the output registers.
    typedef struct packed {
        logic        pht;
        logic        btb;
        logic        last_br;
        logic [31:0] upd_pc;
        logic [31:0] upd_tgt;
        logic        wrong;
        logic [31:0] fixed_pc;
        logic        wasnt;
        logic [31:0] wasnt_pc;
    } slot_res_t;

    function automatic slot_res_t classify(
        input logic        valid,
        input logic        is_br,
        input logic [31:0] pc,
        input logic        pred_tk,
        input logic [31:0] pred_tgt,
        input logic        taken,
        input logic [31:0] tgt
    );
        slot_res_t r;
        r = '0;
        if (valid && is_br) begin
            r.pht      = 1'b1;
            r.last_br  = taken;
            r.upd_pc   = pc;
            r.btb      = taken;
            r.upd_tgt  = tgt;
            r.wrong    = (pred_tk != taken) || (taken && (pred_tgt != tgt));
            // Fall-through address wraps at 2^32.
            r.fixed_pc = taken ? tgt : pc + 32'd4;
        end else if (valid && pred_tk) begin
            r.wasnt    = 1'b1;
            r.wasnt_pc = pc;
        end
        return r;
    endfunction

    state_t    state_q, state_d;
    slot_res_t res_0, res_1;
    slot_res_t emit;
    slot_res_t pend_q;
    logic      pend_load;
    logic      stall_c;
    logic [3:0] shadow_cnt_q;

    assign res_0 = classify(valid_0_i, is_br_0_i, pc_0_i, pred_tk_0_i,
                            pred_tgt_0_i, taken_0_i, tgt_0_i);
    assign res_1 = classify(valid_1_i, is_br_1_i, pc_1_i, pred_tk_1_i,
                            pred_tgt_1_i, taken_1_i, tgt_1_i);

    // Next-state and emit selection.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        emit      = '0;
        pend_load = 1'b0;
        stall_c   = 1'b0;
        unique case (state_q)
            ST_NORMAL: begin
                if (res_0.wrong || res_0.wasnt) begin
                    // Older slot redirects: the younger slot is wrong-path.
                    emit    = res_0;
                    state_d = ST_SHADOW;
                end else if (res_0.pht && res_1.pht) begin
                    // Two updates, one port: park slot 1 and hold the pair.
                    emit      = res_0;
                    pend_load = 1'b1;
                    stall_c   = 1'b1;
                    state_d   = ST_PEND;
                end else if (res_0.pht) begin
                    // A false hit in slot 1 uses its own output port, so it
                    // can go out alongside slot 0's update.
                    emit = res_0;
                    if (res_1.wasnt) begin
                        emit.wasnt    = 1'b1;
                        emit.wasnt_pc = res_1.wasnt_pc;
                        state_d       = ST_SHADOW;
                    end
                end else begin
                    // Slot 0 produces nothing here; slot 1 (if anything) goes out.
                    emit = res_1;
                    if (res_1.wrong || res_1.wasnt) state_d = ST_SHADOW;
                end
            end
            ST_PEND: begin
                // The pair on the inputs was already evaluated; ignore it.
                emit    = pend_q;
                state_d = pend_q.wrong ? ST_SHADOW : ST_NORMAL;
            end
            ST_SHADOW: begin
                if (shadow_cnt_q == 4'd1) state_d = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    assign stall_o = stall_c & ~reset_i;

    // State, shadow counter and pending slot.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_NORMAL;
            shadow_cnt_q <= 4'd0;
            // NOTE: the pending entry is cleared on reset too; a stale entry
            // must never be replayed after reset even though a valid bit
            // (the PEND state) guards it.
            pend_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            if (state_d == ST_SHADOW && state_q != ST_SHADOW) begin
                shadow_cnt_q <= 4'(SHADOW_CYCLES);
            end else if (state_q == ST_SHADOW) begin
                shadow_cnt_q <= shadow_cnt_q - 4'd1;
            end
            if (pend_load) pend_q <= res_1;
        end
    end

    // Output registers: pulses every cycle, payloads only with their pulse.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            update_pht_o   <= 1'b0;
            update_btb_o   <= 1'b0;
            wrong_pred_o   <= 1'b0;
            wasnt_branch_o <= 1'b0;
            last_br_o      <= 1'b0;
            update_pc_o    <= '0;
            update_tgt_o   <= '0;
            fixed_pc_o     <= '0;
            wasnt_br_pc_o  <= '0;
        end else begin
            update_pht_o   <= emit.pht;
            update_btb_o   <= emit.btb;
            wrong_pred_o   <= emit.wrong;
            wasnt_branch_o <= emit.wasnt;
            if (emit.pht) begin
                last_br_o    <= emit.last_br;
                update_pc_o  <= emit.upd_pc;
                update_tgt_o <= emit.upd_tgt;
            end
            if (emit.wrong) fixed_pc_o    <= emit.fixed_pc;
            if (emit.wasnt) wasnt_br_pc_o <= emit.wasnt_pc;
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Counters step on the same edge their pulse is registered and stick at
    // all-ones.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            perf_br_cnt_o      <= '0;
            perf_mispred_cnt_o <= '0;
        end else begin
            if (emit.pht && perf_br_cnt_o != 32'hFFFF_FFFF)
                perf_br_cnt_o <= perf_br_cnt_o + 32'd1;
            if (emit.wrong && perf_mispred_cnt_o != 32'hFFFF_FFFF)
                perf_mispred_cnt_o <= perf_mispred_cnt_o + 32'd1;
        end
    end
`endif

endmodule
